sipo: RTL and testbench

SIPO -- requirements
Module: sipo

---
 rtl/sipo_pkg.sv | 21 ++
 rtl/sipo_bit_cnt.sv | 51 +++++
 rtl/sipo.sv | 177 +++++++++++++++++
 tb/tb_sipo.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// ---------------------------------------------------------------------------
// sipo_pkg
// Shared definitions for the serial-in / parallel-out receiver:
//   - SIPO_DEFAULT_WIDTH : default number of data bits per word
//   - sipo_state_e       : output FSM encodings (COLLECT, HOLD)
//   - cnt_bits()         : width of a counter able to hold 0..max_count
// ---------------------------------------------------------------------------
package sipo_pkg;

   localparam int SIPO_DEFAULT_WIDTH = 4;

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } sipo_state_e;

   function automatic int cnt_bits(input int max_count);
      return (max_count < 1) ? 1 : $clog2(max_count + 1);
   endfunction

endpackage

// File: rtl/sipo_bit_cnt.sv
// ---------------------------------------------------------------------------
// sipo_bit_cnt
// Frame bit counter for the SIPO receiver. Counts enabled clock edges
// 0..max_count and wraps back to 0 on the edge after max_count.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous reset, active-low
//   en     in   advance the counter on this edge
//   count  out  index of the bit sampled on the next enabled edge
//   wrap   out  high when the coming enabled edge is the last of the frame
// ---------------------------------------------------------------------------
module sipo_bit_cnt
   import sipo_pkg::*;
#(
   parameter int max_count = 3,
   parameter int cnt_w     = cnt_bits(max_count)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [cnt_w-1:0] count,
   output logic             wrap
);

   localparam logic [cnt_w-1:0] LAST = cnt_w'(max_count);

   logic [cnt_w-1:0] count_q;
   logic [cnt_w-1:0] count_d;

   // wrap is combinational so the parent sees completion on the same edge
   // that samples the final bit of the frame.
   assign wrap  = en && (count_q == LAST);
   assign count = count_q;

   always_comb begin
      count_d = count_q;
      if (en) begin
         count_d = wrap ? '0 : count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/sipo.sv
// ---------------------------------------------------------------------------
// sipo
// Serial-in / parallel-out receiver with a one-word output register and a
// valid/ready handshake. Bits arrive MSB first on serial_in, qualified by
// shift. A completed word is presented on parallel_out with out_valid; if a
// second word completes while the first is still unconsumed, the new word is
// dropped and overrun pulses for one cycle.
//
// Optional feature macro: SIPO_PARITY_EN
//   When defined, each frame is width data bits followed by one even-parity
//   bit, and parity_err reports a mismatch alongside the loaded word.
//
// Ports:
//   clk           in   rising-edge clock
//   rst           in   asynchronous reset, active-low
//   shift         in   serial bit strobe
//   serial_in     in   serial data, MSB first
//   parallel_out  out  last completed word (width bits)
//   out_valid     out  parallel_out holds an unconsumed word
//   out_ready     in   consumer accepts the word when out_valid is high
//   overrun       out  one-cycle pulse: completed word dropped
//   parity_err    out  parity mismatch of the held word (SIPO_PARITY_EN only)
// ---------------------------------------------------------------------------
module sipo
   import sipo_pkg::*;
#(
   parameter int width = SIPO_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             shift,
   input  logic             serial_in,
   output logic [width-1:0] parallel_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             overrun
`ifdef SIPO_PARITY_EN
   ,
   output logic             parity_err
`endif
);

`ifdef SIPO_PARITY_EN
   localparam int LAST_IDX = width;
`else
   localparam int LAST_IDX = width - 1;
`endif
   localparam int CNT_W = cnt_bits(LAST_IDX);

   logic [CNT_W-1:0] bit_idx;
   logic             word_done;

   logic [width-1:0] shift_q;
   logic [width-1:0] shift_d;
   logic [width-1:0] out_q;
   logic [width-1:0] out_d;
   sipo_state_e      state_q;
   sipo_state_e      state_d;
   logic             overrun_q;
   logic             overrun_d;
   logic             take_data;
   logic [width-1:0] new_word;

   sipo_bit_cnt #(
      .max_count (LAST_IDX),
      .cnt_w     (CNT_W)
   ) u_bit_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (shift),
      .count (bit_idx),
      .wrap  (word_done)
   );

`ifdef SIPO_PARITY_EN
   logic perr_q;
   logic perr_d;
   logic new_perr;

   // The parity bit is not part of the data word, so it never enters the
   // shift register; the completed word is what is already in it.
   assign take_data = shift && (bit_idx != CNT_W'(width));
   assign new_word  = shift_q;
   assign new_perr  = (^shift_q) ^ serial_in;
`else
   // The last data bit completes the word, so it is merged in directly
   // rather than waiting for it to land in the shift register.
   assign take_data = shift;
   assign new_word  = {shift_q[width-2:0], serial_in};
`endif

   // Shift register: bit 0 of a frame starts from a clean register so stale
   // bits of an earlier word never linger in the low positions.
   always_comb begin
      shift_d = shift_q;
      if (take_data) begin
         if (bit_idx == '0) begin
            shift_d = {{(width-1){1'b0}}, serial_in};
         end else begin
            shift_d = {shift_q[width-2:0], serial_in};
         end
      end
   end

   // Output FSM: HOLD means the output register owns an unconsumed word.
   // A completion in HOLD loads only if the consumer takes the old word on
   // the same edge; otherwise the new word is dropped and overrun pulses.
   always_comb begin
      state_d   = state_q;
      out_d     = out_q;
      overrun_d = 1'b0;
`ifdef SIPO_PARITY_EN
      perr_d    = perr_q;
`endif
      case (state_q)
         COLLECT: begin
            if (word_done) begin
               out_d   = new_word;
`ifdef SIPO_PARITY_EN
               perr_d  = new_perr;
`endif
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (word_done) begin
               if (out_ready) begin
                  out_d  = new_word;
`ifdef SIPO_PARITY_EN
                  perr_d = new_perr;
`endif
               end else begin
                  overrun_d = 1'b1;
               end
            end else if (out_ready) begin
               state_d = COLLECT;
            end
         end
         default: begin
            state_d = COLLECT;
         end
      endcase
   end

   // State and datapath registers, all cleared by the asynchronous reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shift_q   <= '0;
         out_q     <= '0;
         state_q   <= COLLECT;
         overrun_q <= 1'b0;
      end else begin
         shift_q   <= shift_d;
         out_q     <= out_d;
         state_q   <= state_d;
         overrun_q <= overrun_d;
      end
   end

`ifdef SIPO_PARITY_EN
   // Parity flag travels with the output word and holds with it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perr_q <= 1'b0;
      end else begin
         perr_q <= perr_d;
      end
   end

   assign parity_err = perr_q;
`endif

   assign parallel_out = out_q;
   assign out_valid    = (state_q == HOLD);
   assign overrun      = overrun_q;

endmodule

// File: tb/tb_sipo.sv
// ---------------------------------------------------------------------------
// tb_sipo
// Self-checking bench for sipo at width=4. Expected words are pushed to a
// scoreboard queue as each frame is driven and popped when the completed
// word should appear on parallel_out. Builds with or without SIPO_PARITY_EN;
// with it defined, frames carry a trailing even-parity bit and parity_err
// is checked as well.
// ---------------------------------------------------------------------------
module tb_sipo;

   localparam int W = 4;
`ifdef SIPO_PARITY_EN
   localparam bit PAR_ON = 1'b1;
`else
   localparam bit PAR_ON = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         shift;
   logic         serial_in;
   logic [W-1:0] parallel_out;
   logic         out_valid;
   logic         out_ready;
   logic         overrun;
`ifdef SIPO_PARITY_EN
   logic         parity_err;
`endif

   int           checkCount = 0;
   int           passCount  = 0;
   logic [W:0]   expQ[$];
   logic [W-1:0] heldWord = '0;
   logic         heldPerr = 1'b0;

   sipo #(
      .width (W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .shift        (shift),
      .serial_in    (serial_in),
      .parallel_out (parallel_out),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .overrun      (overrun)
`ifdef SIPO_PARITY_EN
      ,
      .parity_err   (parity_err)
`endif
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   // One comparison: counts it, and on mismatch reports tag/observed/expected.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   // One strobed bit; inputs change 1 time unit after an edge.
   task automatic applyStimulus(input logic b, input logic rdy);
      shift     = 1'b1;
      serial_in = b;
      out_ready = rdy;
      @(posedge clk);
      #1;
      shift     = 1'b0;
   endtask

   task automatic idleCycle(input logic rdy);
      shift     = 1'b0;
      out_ready = rdy;
      @(posedge clk);
      #1;
   endtask

   // Drives a full frame MSB first. rdyLast applies on the completing edge
   // (last data bit, or the parity bit when parity is enabled).
   task automatic sendWord(input logic [W-1:0] w, input logic rdyEarly,
                           input logic rdyLast, input logic par);
      for (int i = W - 1; i >= 0; i--) begin
         if (i == 0 && !PAR_ON) applyStimulus(w[i], rdyLast);
         else                   applyStimulus(w[i], rdyEarly);
      end
      if (PAR_ON) applyStimulus(par, rdyLast);
   endtask

   task automatic pushExpected(input logic [W-1:0] w, input logic perr);
      expQ.push_back({perr, w});
   endtask

   // Pops the next expected word and compares it against the output register.
   task automatic checkLoad(input string tag);
      logic [W:0] e;
      if (expQ.size() == 0) begin
         checkCount++;
         $error("[TB] FAIL %s observed=load expected=no_pending_word", tag);
      end else begin
         e        = expQ.pop_front();
         heldWord = e[W-1:0];
         heldPerr = e[W];
         checkOutput({tag, "_data"}, parallel_out, heldWord);
         checkOutput({tag, "_valid"}, out_valid, 1'b1);
         checkOutput({tag, "_overrun"}, overrun, 1'b0);
`ifdef SIPO_PARITY_EN
         checkOutput({tag, "_perr"}, parity_err, heldPerr);
`endif
      end
   endtask

   initial begin
      rst       = 1'b0;
      shift     = 1'b0;
      serial_in = 1'b0;
      out_ready = 1'b0;
      #1;

      // Strobes during reset must be ignored.
      shift     = 1'b1;
      serial_in = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      shift = 1'b0;
      checkOutput("reset_data", parallel_out, '0);
      checkOutput("reset_valid", out_valid, 1'b0);
      checkOutput("reset_overrun", overrun, 1'b0);
`ifdef SIPO_PARITY_EN
      checkOutput("reset_perr", parity_err, 1'b0);
`endif
      rst = 1'b1;

      // Reset mid-word after two bits; the partial bits must be discarded.
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
      #2 rst = 1'b0;
      #1;
      checkOutput("midrst_valid", out_valid, 1'b0);
      checkOutput("midrst_data", parallel_out, '0);
      #2 rst = 1'b1;
      pushExpected(4'b1011, 1'b0);
      sendWord(4'b1011, 1'b0, 1'b0, 1'b1);
      checkLoad("rst_word");
      idleCycle(1'b1);
      checkOutput("rst_consume_valid", out_valid, 1'b0);
      checkOutput("rst_consume_data", parallel_out, heldWord);

      // Back-to-back frames with the consumer always ready.
      pushExpected(4'b1001, 1'b0);
      sendWord(4'b1001, 1'b1, 1'b1, 1'b0);
      checkLoad("b2b_first");
      pushExpected(4'b0110, 1'b0);
      sendWord(4'b0110, 1'b1, 1'b1, 1'b0);
      checkLoad("b2b_second");
      idleCycle(1'b1);
      checkOutput("b2b_consume_valid", out_valid, 1'b0);

      // Overrun: second word completes while the first is still held.
      pushExpected(4'b1001, 1'b0);
      sendWord(4'b1001, 1'b0, 1'b0, 1'b0);
      checkLoad("ovr_first");
      sendWord(4'b0110, 1'b0, 1'b0, 1'b0);
      checkOutput("ovr_pulse", overrun, 1'b1);
      checkOutput("ovr_data_kept", parallel_out, heldWord);
      checkOutput("ovr_valid_kept", out_valid, 1'b1);
      idleCycle(1'b0);
      checkOutput("ovr_pulse_end", overrun, 1'b0);
      checkOutput("ovr_valid_after", out_valid, 1'b1);
      checkOutput("ovr_data_after", parallel_out, heldWord);

      // Completion coincides with the handshake of the held word.
      pushExpected(4'b1100, 1'b0);
      sendWord(4'b1100, 1'b0, 1'b1, 1'b0);
      checkLoad("simul");
      idleCycle(1'b1);
      checkOutput("simul_consume_valid", out_valid, 1'b0);

      // Gapped strobes: three idle cycles between bits, word 1101.
      pushExpected(4'b1101, 1'b0);
      begin
         logic [W-1:0] gw;
         gw = 4'b1101;
         for (int i = W - 1; i >= 0; i--) begin
            applyStimulus(gw[i], 1'b0);
            if (i != 0 || PAR_ON) begin
               repeat (3) idleCycle(1'b0);
               checkOutput("gap_valid_low", out_valid, 1'b0);
               checkOutput("gap_data_held", parallel_out, heldWord);
            end
         end
         if (PAR_ON) applyStimulus(^gw, 1'b0);
      end
      checkLoad("gap");

      // out_ready while nothing is held has no effect.
      idleCycle(1'b1);
      idleCycle(1'b1);
      checkOutput("idle_ready_valid", out_valid, 1'b0);
      checkOutput("idle_ready_data", parallel_out, heldWord);
      checkOutput("idle_ready_overrun", overrun, 1'b0);

`ifdef SIPO_PARITY_EN
      // Parity: 1001+0 is even, 1000+0 is a mismatch.
      pushExpected(4'b1001, 1'b0);
      sendWord(4'b1001, 1'b0, 1'b0, 1'b0);
      checkLoad("par_good");
      idleCycle(1'b1);
      pushExpected(4'b1000, 1'b1);
      sendWord(4'b1000, 1'b0, 1'b0, 1'b0);
      checkLoad("par_bad");
      idleCycle(1'b0);
      checkOutput("par_bad_hold", parity_err, 1'b1);
      idleCycle(1'b1);
`endif

      // Asynchronous reset while a word is held clears the output at once.
      pushExpected(4'b0011, 1'b0);
      sendWord(4'b0011, 1'b0, 1'b0, 1'b0);
      checkLoad("pre_rst");
      #2 rst = 1'b0;
      #1;
      checkOutput("async_rst_data", parallel_out, '0);
      checkOutput("async_rst_valid", out_valid, 1'b0);
      #2 rst = 1'b1;
      idleCycle(1'b0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
